// File: rtl/nextpc_pkg.sv
// Shared constants, redirect-kind encodings and priority ranking for the
// next-PC generator.
package nextpc_pkg;

  // Default fetch vectors (module parameters default to these)
  localparam logic [31:0] DEF_RESET_VEC  = 32'hbfc00000;
  localparam logic [31:0] DEF_REFILL_VEC = 32'hbfc00200;
  localparam logic [31:0] DEF_EXC_VEC    = 32'hbfc00380;

  // Kind of a deferred (or live) redirect
  typedef enum logic [1:0] {
    PK_NONE = 2'd0,
    PK_BR   = 2'd1,
    PK_ERET = 2'd2
  } pend_kind_e;

  // Priority rank of a redirect kind; higher wins, ERET outranks branch
  function automatic logic [1:0] pk_rank(input pend_kind_e kind);
    logic [1:0] rank;
    case (kind)
      PK_ERET: rank = 2'd2;
      PK_BR:   rank = 2'd1;
      PK_NONE: rank = 2'd0;
      default: rank = 2'd0;
    endcase
    return rank;
  endfunction

endpackage

// File: rtl/nextpc_ctrl_br_target_calc.sv
// Combinational control-transfer target calculator. When several kind flags
// are set, the PC-relative branch wins over the jump, which wins over the
// register jump.
module br_target_calc (
  input  logic [31:0] fe_pc,
  input  logic [15:0] offset,
  input  logic [25:0] index,
  input  logic [31:0] jr_target,
  input  logic        is_br,
  input  logic        is_j,
  input  logic        is_jr,
  output logic [31:0] target,
  output logic        valid
);

  // Select the target by kind priority; no kind flag means no redirect
  always_comb begin
    target = 32'd0;
    valid  = 1'b0;
    if (is_br) begin
      target = fe_pc + {{14{offset[15]}}, offset, 2'b00};
      valid  = 1'b1;
    end else if (is_j) begin
      target = {fe_pc[31:28], index, 2'b00};
      valid  = 1'b1;
    end else if (is_jr) begin
      target = jr_target;
      valid  = 1'b1;
    end else begin
      target = 32'd0;
      valid  = 1'b0;
    end
  end

endmodule

// File: rtl/nextpc_ctrl.sv
// Next fetch address generator: exception vectors, ERET, branch/jump targets
// and sequential PC+4, with stall hold and deferral of redirects that arrive
// while fetch is stalled.
module nextpc_ctrl
  import nextpc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC   = DEF_RESET_VEC,
  parameter logic [31:0] REFILL_VEC  = DEF_REFILL_VEC,
  parameter logic [31:0] EXC_VEC     = DEF_EXC_VEC,
  parameter int          TLB_EXC_W   = 6,
  parameter int          REFILL_BITS = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 stall,
  input  logic [31:0]          fe_pc,
  input  logic                 br_taken,
  input  logic                 br_is_br,
  input  logic                 br_is_j,
  input  logic                 br_is_jr,
  input  logic [15:0]          br_offset,
  input  logic [25:0]          br_index,
  input  logic [31:0]          br_target,
  input  logic                 excp,
  input  logic                 late_excp,
  input  logic [TLB_EXC_W-1:0] tlb_exce,
  input  logic                 eret,
  input  logic [31:0]          epc,
  output logic [31:0]          nextpc,
  output logic                 pend_valid,
  output logic [1:0]           pend_kind
);

  logic [31:0] hold_pc;
  logic [31:0] pend_pc;
  pend_kind_e  pend_kind_q;
  logic        pend_valid_q;

  logic [31:0] calc_target;
  logic        calc_valid;
  logic        refill;
  logic        urgent_exc;
  pend_kind_e  live_kind;
  logic [31:0] live_pc;

  // One calculator serves both the live path and the stall capture path,
  // since both use the current-cycle decode fields.
  br_target_calc u_calc (
    .fe_pc     (fe_pc),
    .offset    (br_offset),
    .index     (br_index),
    .jr_target (br_target),
    .is_br     (br_is_br),
    .is_j      (br_is_j),
    .is_jr     (br_is_jr),
    .target    (calc_target),
    .valid     (calc_valid)
  );

  assign refill     = |tlb_exce[REFILL_BITS-1:0];
  assign urgent_exc = excp | late_excp | (|tlb_exce[TLB_EXC_W-1:REFILL_BITS]);

  // Highest-priority live redirect this cycle (ERET over branch), else PC+4
  always_comb begin
    live_kind = PK_NONE;
    live_pc   = fe_pc + 32'd4;
    if (eret) begin
      live_kind = PK_ERET;
      live_pc   = epc;
    end else if (br_taken && calc_valid) begin
      live_kind = PK_BR;
      live_pc   = calc_target;
    end else begin
      live_kind = PK_NONE;
      live_pc   = fe_pc + 32'd4;
    end
  end

  // Final next-PC mux; a held redirect only beats a strictly lower live class
  always_comb begin
    nextpc = RESET_VEC;
    if (!resetn) begin
      nextpc = RESET_VEC;
    end else if (refill) begin
      nextpc = REFILL_VEC;
    end else if (urgent_exc) begin
      nextpc = EXC_VEC;
    end else if (stall) begin
      nextpc = hold_pc;
    end else if (pend_valid_q && (pk_rank(pend_kind_q) > pk_rank(live_kind))) begin
      nextpc = pend_pc;
    end else begin
      nextpc = live_pc;
    end
  end

  // Hold register and deferred-redirect capture/release
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_pc      <= RESET_VEC;
      pend_valid_q <= 1'b0;
      pend_kind_q  <= PK_NONE;
      pend_pc      <= 32'd0;
    end else if (refill || urgent_exc) begin
      hold_pc      <= nextpc;
      pend_valid_q <= 1'b0;
      pend_kind_q  <= PK_NONE;
    end else if (stall) begin
      if ((live_kind != PK_NONE) && (pk_rank(live_kind) >= pk_rank(pend_kind_q))) begin
        pend_valid_q <= 1'b1;
        pend_kind_q  <= live_kind;
        pend_pc      <= live_pc;
      end else begin
        pend_valid_q <= pend_valid_q;
        pend_kind_q  <= pend_kind_q;
      end
    end else begin
      hold_pc      <= nextpc;
      pend_valid_q <= 1'b0;
      pend_kind_q  <= PK_NONE;
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_kind  = pend_kind_q;

endmodule

// File: doc/nextpc_ctrl.md
Name: nextpc_ctrl

Overview:
- Parametrised next-PC generator for the fetch stage. Selects the next fetch address from several sources: reset vector, TLB-refill vector, general exception vector, ERET return (EPC), branch/jump/jump-register target, or sequential PC+4.
- Holds the fetch address across stalls.
- Captures any ERET or branch redirect that arrives during a stall and applies it when the stall releases, so no redirect is ever lost.
- Sits between decode/CP0 and the instruction-fetch PC register.

Parameters:
- RESET_VEC, 32'hbfc00000, fetch address after reset.
- REFILL_VEC, 32'hbfc00200, TLB-refill exception vector.
- EXC_VEC, 32'hbfc00380, general exception vector.
- TLB_EXC_W, 6, width of tlb_exce.
- REFILL_BITS, 2, number of low tlb_exce bits that denote refill; the remaining bits denote general TLB exceptions.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- stall  in  1  fetch stall; hold the current fetch address
- fe_pc  in  32  PC of the instruction currently in fetch/decode
- br_taken  in  1  decode resolved a taken control transfer
- br_is_br  in  1  target = fe_pc + sign-extended offset
- br_is_j  in  1  target = {fe_pc[31:28], index, 2'b00}
- br_is_jr  in  1  target = br_target
- br_offset  in  16  branch offset field
- br_index  in  26  jump instr_index field
- br_target  in  32  register-sourced target
- excp  in  1  general exception from the pipeline
- late_excp  in  1  late (execute-stage) exception, e.g. divide; replaces ad-hoc detection
- tlb_exce  in  TLB_EXC_W  TLB exception flags
- eret  in  1  ERET retiring
- epc  in  32  CP0 EPC
- nextpc  out  32  next fetch address
- pend_valid  out  1  a deferred redirect is held
- pend_kind  out  2  kind of held redirect: 0 none, 1 branch, 2 eret

Behaviour:
- Reset (resetn=0 at a clk edge):
  - hold register (hold_pc) <= RESET_VEC; pend_valid <= 0; pend_kind <= 0.
  - While resetn=0, nextpc = RESET_VEC combinationally.
- Source classes:
  - refill = |tlb_exce[REFILL_BITS-1:0].
  - urgent_exc = excp | late_excp | |tlb_exce[TLB_EXC_W-1:REFILL_BITS].
  - Priority: refill > urgent_exc > eret > branch > sequential.
- Branch target:
  - br: fe_pc + {{14{off[15]}}, off, 2'b00}, modulo 2^32 (wraps).
  - j: {fe_pc[31:28], index, 2'b00}.
  - jr: br_target.
  - If more than one is_* flag is set, priority br > j > jr.
  - br_taken with no is_* flag set = sequential (no redirect).
- Exceptions are urgent and ignore stall:
  - refill -> nextpc = REFILL_VEC; otherwise urgent_exc -> nextpc = EXC_VEC.
  - Same cycle: hold_pc <= the vector, pend_valid <= 0 (the exception flushes any held branch/eret).
- stall=1, no exception:
  - nextpc = hold_pc.
  - If eret or br_taken is asserted, capture the redirect into the pend register (target computed from the current-cycle fe_pc/epc).
  - A new capture replaces the held one only if its priority is greater than or equal to the held one (eret over branch; the later of two equals wins).
  - hold_pc is unchanged.
- stall=0, no exception:
  - nextpc = highest priority of {live eret, live branch, pend} by the priority above; a pend entry of equal class to a live source loses to the live source.
  - Otherwise fe_pc + 4.
  - pend_valid <= 0; hold_pc <= nextpc.
- Latency:
  - Live sources: zero cycles (combinational to nextpc).
  - Deferred redirect: nextpc in the first cycle with stall=0.
- Reset mid-stall with pend_valid=1: pend is discarded and nextpc = RESET_VEC.
- No output may be X after the first reset edge.

Decomposition:
- Shared package nextpc_pkg:
  - default vector constants RESET_VEC, REFILL_VEC, EXC_VEC;
  - pend_kind encodings PK_NONE/PK_BR/PK_ERET;
  - a priority-rank function.
- One combinational sub-module br_target_calc (fe_pc, offset, index, target, is_* -> target, valid). It is instantiated for both the live path and the capture path, sharing one instance.

Test Plan:
- Reset then release, stall=0, fe_pc=32'hbfc00000 -> nextpc = bfc00000 during reset, then bfc00004; pend_valid=0.
- fe_pc=32'h80001000, br_taken=1, br_is_br=1, off=16'hfffe, stall=0 -> nextpc = 80000ff8 in the same cycle. Repeat with fe_pc=0, off=16'h8000 -> nextpc = fffe0000 (wrap).
- stall=1 with br_taken=1, br_is_j=1, index=26'h0000400, fe_pc=32'h9000_0000; hold 3 cycles, then stall=0 -> nextpc = hold_pc for 3 cycles, pend_kind=1, then nextpc = 90001000 and pend_valid drops next edge.
- stall=1: branch captured, then eret with epc=32'h8000_0200 two cycles later; release -> pend_kind goes 1 then 2; nextpc = 80000200 on release.
- stall=1 with pend branch held, then tlb_exce=6'b000001 -> nextpc = bfc00200 immediately; pend_valid=0. With tlb_exce=6'b000100 and excp=1 -> bfc00380.
- late_excp=1 together with br_taken=1, stall=0 -> nextpc = bfc00380. Then resetn=0 with pend held -> nextpc = bfc00000; pend_valid=0 after the edge.
